ps2_scan_rx: RTL and testbench
==============================

PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000, meaning idle cycles allowed between PS/2 clock falling edges inside a frame (100 us at 50 MHz).
REQ-002 SHALL have port CLK_50M  input  1  system clock; one clock domain, all logic on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port ps2k_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-005 SHALL have port ps2k_data  input  1  raw PS/2 data from the keyboard, asynchronous.
REQ-006 SHALL have port ps2_byte  output  8  last completed scan code, excluding E0/F0 prefixes.
REQ-007 SHALL have port ps2_state  output  1  one-cycle pulse, ps2_byte/ps2_ext/ps2_break valid.
REQ-008 SHALL have port ps2_ext  output  1  an E0 prefix preceded ps2_byte.
REQ-009 SHALL have port ps2_break  output  1  an F0 prefix preceded ps2_byte (key release).
REQ-010 SHALL have port ps2_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Function
REQ-011 SHALL pass ps2k_clk and ps2k_data through two-flop synchronizers, then register the synchronized clock once more for edge detection.
REQ-012 SHALL treat a falling edge as sync_clk_d=1 and sync_clk=0; data SHALL be sampled from sync_data in that cycle.
REQ-013 FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: on a falling edge with data=0 (start bit), go to DATA and clear the bit counter; with data=1, stay in IDLE and take no action.
REQ-015 DATA: shift in 8 bits LSB-first, one per falling edge; after the 8th bit, go to PARITY.
REQ-016 PARITY: sample the parity bit, flag an error if the XOR of the 8 data bits and the parity bit is not 1 (odd parity), then go to STOP.
REQ-017 STOP: sample the stop bit, then go to IDLE; a frame is good only when parity is correct and the stop bit is 1.
REQ-018 On a good frame with byte E0: set the internal ext flag; no ps2_state pulse.
REQ-019 On a good frame with byte F0: set the internal break flag; no ps2_state pulse.
REQ-020 On any other good byte: in the next cycle, load ps2_byte, ps2_ext and ps2_break from the byte and flags, pulse ps2_state for exactly one cycle, then clear both flags.
REQ-021 Latency: the ps2_state pulse occurs exactly 1 cycle after the cycle in which the stop-bit falling edge is detected.
REQ-022 On a bad frame: pulse ps2_err for one cycle (same timing as ps2_state), clear both flags, leave ps2_byte/ps2_ext/ps2_break unchanged, no ps2_state pulse.
REQ-023 Timeout counter: clears on every falling edge and counts while the FSM is not IDLE.
REQ-024 On reaching TIMEOUT_CYCLES-1: go to IDLE, pulse ps2_err, clear both flags, discard the partial byte.
REQ-025 Between frames (FSM in IDLE), the prefix flags SHALL persist with no timeout.
REQ-026 A sequence E0 F0 <code> SHALL report ps2_ext=1 and ps2_break=1; a repeated prefix is idempotent.
REQ-027 ps2_byte, ps2_ext and ps2_break SHALL hold their values between pulses.

Reset
REQ-028 While RST_N=0 at a clock edge, the following SHALL reset: FSM to IDLE, bit counter, shift register and timeout counter to 0, flags to 0, ps2_byte to 8'h00, ps2_ext, ps2_break, ps2_state and ps2_err to 0, synchronizer flops to 1 (bus idle).
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, the FSM SHALL wait in IDLE for the next start bit.

Structure
REQ-030 The FSM state encoding and the constants PS2_EXT_CODE=8'hE0 and PS2_BRK_CODE=8'hF0 SHALL live in the shared game package, for reuse by the keyboard decoders.
REQ-031 One sub-module, ps2_sync_edge, SHALL contain the synchronizers and the falling-edge detector; the FSM, counters and flags stay in ps2_scan_rx.

Verification
REQ-032 Frame 0x1C (parity 0, stop 1) -> one ps2_state pulse, ps2_byte=8'h1C, ext=0, break=0.
REQ-033 Frames F0, 1C -> single pulse after the second frame, ps2_byte=8'h1C, break=1; the next plain frame 0x1C reports break=0.
REQ-034 Frames E0, F0, 6B -> ps2_byte=8'h6B, ext=1, break=1, exactly one pulse.
REQ-035 Frame 0x1C with parity 1 -> ps2_err pulse, no ps2_state pulse, ps2_byte keeps its previous value.
REQ-036 Start bit plus 4 data bits, then clock held high for 5000 cycles -> ps2_err pulse, FSM in IDLE; the following good frame 0x74 decodes correctly.
REQ-037 RST_N low for 1 cycle after bit 5 of a frame -> no pulse; the next full frame 0x29 decodes correctly.

Source files
------------

// File: rtl/ps2_scan_rx_pkg.sv
// Shared PS/2 definitions: receiver FSM encoding and the scan-code prefix bytes
// reused by the keyboard decoders.
package ps2_scan_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_fsm_e;

  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the asynchronous PS/2 clock and data into the system domain and flags
// falling edges of the synchronized PS/2 clock.
module ps2_sync_edge (
  input  logic CLK_50M,
  input  logic RST_N,
  input  logic ps2k_clk,
  input  logic ps2k_data,
  output logic sync_data,
  output logic fall
);

  logic clk_p0, clk_p1, clk_p2;
  logic data_p0, data_p1;

  // Stage p0/p1: two-flop synchronizers; stage p2: delayed clock for edge detect.
  // Reset to 1 so a released bus does not look like a start edge.
  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      clk_p2  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      clk_p0  <= ps2k_clk;
      clk_p1  <= clk_p0;
      clk_p2  <= clk_p1;
      data_p0 <= ps2k_data;
      data_p1 <= data_p0;
    end
  end

  assign sync_data = data_p1;
  assign fall      = clk_p2 & ~clk_p1;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds E0/F0 prefixes into
// ext/break flags and reports each completed scan code with a one-cycle pulse.
module ps2_scan_rx
  import ps2_scan_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic [7:0] ps2_byte,
  output logic       ps2_state,
  output logic       ps2_ext,
  output logic       ps2_break,
  output logic       ps2_err
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic             sync_data, fall;
  ps2_fsm_e         state, state_nxt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             par_ok;
  logic [TMO_W-1:0] tmo_cnt;
  logic             ext_flag, brk_flag;
  logic             tmo_hit, start_bit, shift_en, par_en, frame_end;
  logic             frame_good, frame_bad;

  ps2_sync_edge u_sync (
    .CLK_50M   (CLK_50M),
    .RST_N     (RST_N),
    .ps2k_clk  (ps2k_clk),
    .ps2k_data (ps2k_data),
    .sync_data (sync_data),
    .fall      (fall)
  );

  // A falling edge in the same cycle restarts the window instead of expiring it.
  assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK_50M) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tmo_hit) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!sync_data) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    start_bit = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    frame_end = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    start_bit = ~sync_data;
        DATA:    shift_en  = 1'b1;
        PARITY:  par_en    = 1'b1;
        STOP:    frame_end = 1'b1;
        default: ;
      endcase
    end
  end

  assign frame_good = frame_end & par_ok & sync_data;
  assign frame_bad  = frame_end & ~(par_ok & sync_data);

  // Output stage: results register one cycle after the stop-bit edge.
  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      par_ok    <= 1'b0;
      tmo_cnt   <= '0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      ps2_byte  <= 8'h00;
      ps2_ext   <= 1'b0;
      ps2_break <= 1'b0;
      ps2_state <= 1'b0;
      ps2_err   <= 1'b0;
    end else begin
      ps2_state <= 1'b0;
      ps2_err   <= tmo_hit | frame_bad;

      if (fall || state == IDLE || tmo_hit) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (start_bit) bit_cnt <= 3'd0;
      if (shift_en) begin
        shift   <= {sync_data, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en) par_ok <= ^{shift, sync_data};

      if (tmo_hit || frame_bad) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        if (tmo_hit) shift <= 8'h00;
      end else if (frame_good) begin
        if (shift == PS2_EXT_CODE) begin
          ext_flag <= 1'b1;
        end else if (shift == PS2_BRK_CODE) begin
          brk_flag <= 1'b1;
        end else begin
          ps2_byte  <= shift;
          ps2_ext   <= ext_flag;
          ps2_break <= brk_flag;
          ps2_state <= 1'b1;
          ext_flag  <= 1'b0;
          brk_flag  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: directed and random PS/2 frames scored against a
// frame-level model of the prefix/report behaviour.
module tb_ps2_scan_rx;

  localparam int H = 10;

  logic       CLK_50M = 1'b0;
  logic       RST_N = 1'b0;
  logic       ps2k_clk = 1'b1;
  logic       ps2k_data = 1'b1;
  logic [7:0] ps2_byte;
  logic       ps2_state, ps2_ext, ps2_break, ps2_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int st_cnt = 0, er_cnt = 0, st_cyc = 0, er_cyc = 0;
  int stop_cyc = 0, last_fall = 0;

  logic [7:0] m_byte = 8'h00;
  bit m_ext = 0, m_brk = 0, m_oext = 0, m_obrk = 0;

  ps2_scan_rx #(.TIMEOUT_CYCLES(5000)) dut (
    .CLK_50M   (CLK_50M),
    .RST_N     (RST_N),
    .ps2k_clk  (ps2k_clk),
    .ps2k_data (ps2k_data),
    .ps2_byte  (ps2_byte),
    .ps2_state (ps2_state),
    .ps2_ext   (ps2_ext),
    .ps2_break (ps2_break),
    .ps2_err   (ps2_err)
  );

  always #10 CLK_50M = ~CLK_50M;
  always @(posedge CLK_50M) cyc <= cyc + 1;

  always @(negedge CLK_50M) begin
    if (ps2_state === 1'b1) begin st_cnt++; st_cyc = cyc; end
    if (ps2_err === 1'b1)   begin er_cnt++; er_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit cell: data set while the clock is high, then a low half-period.
  task automatic bus_bit(input logic d, input bit is_stop);
    ps2k_data = d;
    repeat (H) @(negedge CLK_50M);
    ps2k_clk  = 1'b0;
    last_fall = cyc;
    if (is_stop) stop_cyc = cyc;
    repeat (H) @(negedge CLK_50M);
    ps2k_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit perr, input bit stop);
    bit p;
    p = (($countones(b) % 2) == 0) ^ perr;
    bus_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) bus_bit(b[i], 0);
    bus_bit(p, 0);
    bus_bit(stop, 1);
    ps2k_data = 1'b1;
    repeat (4) @(negedge CLK_50M);
  endtask

  task automatic send_partial(input int nbits);
    bus_bit(1'b0, 0);
    for (int i = 0; i < nbits; i++) bus_bit(1'($urandom_range(0, 1)), 0);
    ps2k_data = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good, output bit ep, output bit ee);
    ep = 0;
    ee = 0;
    if (!good) begin
      ee = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      ep = 1; m_byte = b; m_oext = m_ext; m_obrk = m_brk; m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit perr, input bit stop);
    int st0, er0;
    bit ep, ee;
    st0 = st_cnt;
    er0 = er_cnt;
    model_frame(b, !perr && stop, ep, ee);
    send_frame(b, perr, stop);
    check({tag, "_state_pulses"}, st_cnt - st0, 32'(ep));
    check({tag, "_err_pulses"}, er_cnt - er0, 32'(ee));
    if (ep) check({tag, "_state_latency"}, st_cyc - stop_cyc, 3);
    if (ee) check({tag, "_err_latency"}, er_cyc - stop_cyc, 3);
    check({tag, "_byte"}, ps2_byte, m_byte);
    check({tag, "_ext"}, ps2_ext, m_oext);
    check({tag, "_break"}, ps2_break, m_obrk);
  endtask

  task automatic model_reset();
    m_byte = 8'h00; m_ext = 0; m_brk = 0; m_oext = 0; m_obrk = 0;
  endtask

  initial begin
    int st0, er0;
    int kind;
    logic [7:0] rb;

    repeat (3) @(negedge CLK_50M);
    check("rst_byte", ps2_byte, 8'h00);
    check("rst_ext", ps2_ext, 0);
    check("rst_break", ps2_break, 0);
    check("rst_state", ps2_state, 0);
    check("rst_err", ps2_err, 0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK_50M);

    run_frame("plain_1c", 8'h1C, 0, 1);

    run_frame("brk_prefix", 8'hF0, 0, 1);
    repeat (5500) @(negedge CLK_50M);
    run_frame("brk_1c", 8'h1C, 0, 1);
    run_frame("after_brk_1c", 8'h1C, 0, 1);

    run_frame("ext_prefix", 8'hE0, 0, 1);
    run_frame("ext_brk_prefix", 8'hF0, 0, 1);
    run_frame("ext_brk_6b", 8'h6B, 0, 1);

    run_frame("bad_parity_1c", 8'h1C, 1, 0 == 1 ? 0 : 1);
    run_frame("bad_stop_33", 8'h33, 0, 0);

    run_frame("ext_twice_a", 8'hE0, 0, 1);
    run_frame("ext_twice_b", 8'hE0, 0, 1);
    run_frame("ext_twice_5a", 8'h5A, 0, 1);

    // Timeout mid-frame, with a pending prefix that must be dropped.
    run_frame("tmo_prefix", 8'hE0, 0, 1);
    st0 = st_cnt;
    er0 = er_cnt;
    send_partial(4);
    for (int i = 0; i < 6000 && er_cnt == er0; i++) @(negedge CLK_50M);
    repeat (20) @(negedge CLK_50M);
    check("tmo_err_pulses", er_cnt - er0, 1);
    check("tmo_state_pulses", st_cnt - st0, 0);
    check("tmo_window", 32'((er_cyc - last_fall >= 4995) && (er_cyc - last_fall <= 5010)), 1);
    m_ext = 0;
    m_brk = 0;
    run_frame("tmo_then_74", 8'h74, 0, 1);

    // Reset in the middle of a frame, with a pending break prefix.
    run_frame("rst_prefix", 8'hF0, 0, 1);
    st0 = st_cnt;
    er0 = er_cnt;
    send_partial(5);
    RST_N = 1'b0;
    @(negedge CLK_50M);
    RST_N = 1'b1;
    model_reset();
    repeat (3 * H) @(negedge CLK_50M);
    check("midrst_state_pulses", st_cnt - st0, 0);
    check("midrst_err_pulses", er_cnt - er0, 0);
    check("midrst_byte", ps2_byte, m_byte);
    run_frame("midrst_then_29", 8'h29, 0, 1);

    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 9));
      rb = 8'($urandom_range(0, 255));
      case (kind)
        0:       run_frame("rnd_ext", 8'hE0, 0, 1);
        1:       run_frame("rnd_brk", 8'hF0, 0, 1);
        2:       run_frame("rnd_badpar", rb, 1, 1);
        3:       run_frame("rnd_badstop", rb, 0, 0);
        default: run_frame("rnd_code", rb, 0, 1);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
